macro_stim_sequencer: RTL and testbench

MACRO_STIM_SEQUENCER -- requirements
Module: macro_stim_sequencer

---
 rtl/macro_stim_sequencer.sv | 110 +++++++++++
 tb/tb_macro_stim_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/macro_stim_sequencer.sv
// Built-in stimulus sequencer: drives LFSR vectors into a macro under test and
// compresses its responses into an 8-bit MISR signature for pass/fail checking.
module macro_stim_sequencer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] count,
  input  logic [7:0] expect_sig,
  input  logic [7:0] resp_in,
  output logic [7:0] stim_out,
  output logic       stim_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  state_t     state, state_next;
  logic [7:0] lfsr;
  logic [7:0] misr;
  logic [7:0] remaining;
  logic [3:0] settle_cnt;
  logic [7:0] seed_fixed;
  logic [7:0] lfsr_adv;
  logic [7:0] misr_adv;

  // All-zero is the LFSR lockup state, so a zero seed is promoted to 0x01.
  assign seed_fixed = (seed == 8'h00) ? 8'h01 : seed;
  assign lfsr_adv   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_adv   = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]} ^ resp_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (count == 8'd0) ? DONE : APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_next = CAPTURE;
      CAPTURE: state_next = (remaining == 8'd1) ? DONE : APPLY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // stim_out is loaded on entry to APPLY so it equals the LFSR throughout
  // APPLY/SETTLE/CAPTURE, and simply holds after the final vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= 8'h01;
      misr       <= 8'h00;
      remaining  <= 8'd0;
      settle_cnt <= 4'd0;
      stim_out   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            misr <= 8'h00;
            if (count != 8'd0) begin
              lfsr      <= seed_fixed;
              remaining <= count;
              stim_out  <= seed_fixed;
            end
          end
        end
        APPLY: begin
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        CAPTURE: begin
          misr      <= misr_adv;
          lfsr      <= lfsr_adv;
          remaining <= remaining - 8'd1;
          if (remaining != 8'd1) stim_out <= lfsr_adv;
        end
        default: begin
        end
      endcase
    end
  end

  assign stim_valid = (state == APPLY) || (state == SETTLE) || (state == CAPTURE);
  assign busy       = stim_valid;
  assign done       = (state == DONE);
  assign signature  = misr;
  assign pass       = (misr == expect_sig);

endmodule

// File: tb/tb_macro_stim_sequencer.sv
// Directed bench for macro_stim_sequencer: hand-computed stimulus sequences,
// signatures, done timing, ignored starts and asynchronous abort.
module tb_macro_stim_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic [7:0] count;
  logic [7:0] expect_sig;
  logic [7:0] resp_in;
  logic [7:0] stim_out;
  logic       stim_valid;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic       pass;

  logic       tie;
  logic [7:0] resp_val;
  logic [7:0] stim_log [0:1101];
  int         total;
  int         bad;

  assign resp_in = tie ? stim_out : resp_val;

  macro_stim_sequencer #(.SETTLE_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .count      (count),
    .expect_sig (expect_sig),
    .resp_in    (resp_in),
    .stim_out   (stim_out),
    .stim_valid (stim_valid),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .pass       (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Start is sampled at the edge this task waits on; that edge is edge 0.
  // Seed/count are scrambled afterwards to show mid-run changes are ignored.
  task automatic kick(input logic [7:0] s, input logic [7:0] n);
    @(negedge clk);
    seed  = s;
    count = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = ~s;
    count = n + 8'd3;
    $display("run seed=%02h count=%0d", s, n);
  endtask

  // Cycle c is sampled at the c-th falling edge after edge 0.
  task automatic watch(input int limit, output int done_cyc, output int done_n, output int busy_n);
    done_cyc = -1;
    done_n   = 0;
    busy_n   = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      stim_log[c] = stim_out;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
  endtask

  initial begin
    int dc, dn, bn;
    logic [7:0] seq5 [0:4];
    logic [7:0] tap_seed [0:2];
    logic [7:0] tap_next [0:2];
    seq5     = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    tap_seed = '{8'h80, 8'h20, 8'h10};
    tap_next = '{8'h01, 8'h41, 8'h21};
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; seed = 8'h00; count = 8'h00;
    expect_sig = 8'h00; tie = 1'b0; resp_val = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_stim", 32'(stim_out), 32'h00);
    chk("rst_valid", 32'(stim_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sig", 32'(signature), 32'h00);
    chk("rst_pass", 32'(pass), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Five vectors, each held four cycles, done in cycle 21.
    kick(8'h01, 8'd5);
    watch(100, dc, dn, bn);
    chk("seq_done_cyc", 32'(dc), 32'd21);
    chk("seq_done_n", 32'(dn), 32'd1);
    chk("seq_busy_n", 32'(bn), 32'd20);
    for (int c = 1; c <= 20; c++) chk("seq_stim", 32'(stim_log[c]), 32'(seq5[(c - 1) / 4]));
    chk("seq_hold", 32'(stim_out), 32'h11);

    // Single-tap seeds exercise each feedback tap.
    for (int i = 0; i < 3; i++) begin
      kick(tap_seed[i], 8'd2);
      watch(100, dc, dn, bn);
      chk("tap_v0", 32'(stim_log[1]), 32'(tap_seed[i]));
      chk("tap_v1", 32'(stim_log[5]), 32'(tap_next[i]));
      chk("tap_done", 32'(dc), 32'd9);
    end

    // Response tied to stimulus.
    tie = 1'b1;
    kick(8'h01, 8'd1);
    watch(100, dc, dn, bn);
    chk("tie1_done", 32'(dc), 32'd5);
    chk("tie1_sig", 32'(signature), 32'h01);
    chk("tie1_pass", 32'(pass), 32'd0);
    kick(8'h01, 8'd2);
    watch(100, dc, dn, bn);
    chk("tie2_done", 32'(dc), 32'd9);
    chk("tie2_sig", 32'(signature), 32'h00);
    chk("tie2_pass", 32'(pass), 32'd1);

    // Zero seed is promoted; a zero-count run goes straight to done.
    kick(8'h00, 8'd1);
    watch(100, dc, dn, bn);
    chk("z_stim", 32'(stim_log[1]), 32'h01);
    chk("z_sig", 32'(signature), 32'h01);
    kick(8'h33, 8'd0);
    watch(100, dc, dn, bn);
    chk("c0_done", 32'(dc), 32'd1);
    chk("c0_done_n", 32'(dn), 32'd1);
    chk("c0_busy_n", 32'(bn), 32'd0);
    chk("c0_sig", 32'(signature), 32'h00);
    chk("c0_stim_hold", 32'(stim_out), 32'h01);

    // Constant response 0xA5 over three vectors: A5 -> EF -> 7A.
    tie = 1'b0;
    resp_val = 8'hA5;
    kick(8'h5A, 8'd3);
    watch(100, dc, dn, bn);
    chk("a5_done", 32'(dc), 32'd13);
    chk("a5_sig", 32'(signature), 32'h7A);
    expect_sig = 8'h7A;
    #1 chk("a5_pass", 32'(pass), 32'd1);
    expect_sig = 8'h00;
    #1 chk("a5_nopass", 32'(pass), 32'd0);
    resp_val = 8'h00;

    // Start pulsed during SETTLE with different seed/count is ignored.
    kick(8'h01, 8'd3);
    fork
      watch(100, dc, dn, bn);
      begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        seed  = 8'hAA;
        count = 8'd7;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("ign_done", 32'(dc), 32'd13);
    chk("ign_busy_n", 32'(bn), 32'd12);
    chk("ign_v2", 32'(stim_log[9]), 32'h04);
    chk("ign_hold", 32'(stim_out), 32'h04);

    // Asynchronous reset in the first SETTLE cycle of vector 3.
    kick(8'h01, 8'd5);
    repeat (10) @(negedge clk);
    chk("ab_pre_busy", 32'(busy), 32'd1);
    chk("ab_pre_stim", 32'(stim_out), 32'h04);
    #2 rst = 1'b1;
    #1;
    chk("ab_stim", 32'(stim_out), 32'h00);
    chk("ab_valid", 32'(stim_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_sig", 32'(signature), 32'h00);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ab_no_done", 32'(dn), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tie = 1'b1;
    kick(8'h01, 8'd2);
    watch(100, dc, dn, bn);
    chk("ab_rerun_done", 32'(dc), 32'd9);
    chk("ab_rerun_sig", 32'(signature), 32'h00);
    chk("ab_rerun_v1", 32'(stim_log[5]), 32'h02);
    tie = 1'b0;

    // Maximum run length.
    resp_val = 8'h00;
    kick(8'h01, 8'd255);
    watch(1100, dc, dn, bn);
    chk("max_done_cyc", 32'(dc), 32'd1021);
    chk("max_done_n", 32'(dn), 32'd1);
    chk("max_busy_n", 32'(bn), 32'd1020);
    chk("max_sig", 32'(signature), 32'h00);
    chk("max_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
